// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer matches a consumer only if it writes, is not $zero, and names the same register.
  function automatic logic regHit(input logic wrEn, input logic [4:0] dst, input logic [4:0] src);
    return wrEn && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// E-stage forwarding select for one source operand; the M stage wins over WB.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output fwdSel_t    fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (regHit(regWriteM, writeRegM, src)) begin
      fwdSel = FWD_MEM;
    end else if (regHit(regWriteW, writeRegW, src)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward control for the 5-stage MIPS pipe with a memory-wait FSM.
// Optional stall-cycle counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic             CLK_HazU,
  input  logic             RST_HazU,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JumpD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MemTimeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] StallCnt
`endif
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  hazState_t         state, stateNext;
  logic [WCNT_W-1:0] waitCnt, waitCntNext;
  logic              lwStall, brStall, memStall, timeoutNow;
  fwdSel_t           fwdA, fwdB;

  hazard_fwd_sel uFwdA (
    .src      (RsE),
    .writeRegM(WriteRegM),
    .writeRegW(WriteRegW),
    .regWriteM(RegWriteM),
    .regWriteW(RegWriteW),
    .fwdSel   (fwdA)
  );

  hazard_fwd_sel uFwdB (
    .src      (RtE),
    .writeRegM(WriteRegM),
    .writeRegW(WriteRegW),
    .regWriteM(RegWriteM),
    .regWriteW(RegWriteW),
    .fwdSel   (fwdB)
  );

  assign lwStall = MemtoRegE && (RtE != REG_ZERO) && ((RtE == RsD) || (RtE == RtD));

  // Branch compares in D: wait for an ALU result still in E, or a load result still in M.
  assign brStall = BranchD &&
                   (regHit(RegWriteE, WriteRegE, RsD) || regHit(RegWriteE, WriteRegE, RtD) ||
                    regHit(MemtoRegM, WriteRegM, RsD) || regHit(MemtoRegM, WriteRegM, RtD));

  assign timeoutNow = (state == MEMWAIT) && (waitCnt == WAIT_LAST) && !MemReadyM;

  assign memStall = ((state == RUN) && MemReqM && !MemReadyM) ||
                    ((state == MEMWAIT) && !MemReadyM && !timeoutNow);

  always_ff @(posedge CLK_HazU) begin
    if (RST_HazU) begin
      state      <= RUN;
      waitCnt    <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (timeoutNow) begin
        MemTimeout <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          stateNext   = MEMWAIT;
          waitCntNext = WCNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (MemReadyM || timeoutNow) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (RST_HazU) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwdA;
      ForwardBE = fwdB;
      ForwardAD = regHit(RegWriteM, WriteRegM, RsD);
      ForwardBD = regHit(RegWriteM, WriteRegM, RtD);
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (lwStall || brStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (PCSrcD || JumpD) begin
        FlushD = 1'b1;
      end
      // An aborted access must not retire into WB.
      if (timeoutNow) begin
        FlushW = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK_HazU) begin
    if (RST_HazU) begin
      StallCnt <= '0;
    end else if (StallF && (StallCnt != '1)) begin
      StallCnt <= StallCnt + 1'b1;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed-vector bench for hazard_ctrl_unit (MEM_TIMEOUT=4).
module tb_hazard_ctrl_unit;

  logic       CLK_HazU = 1'b0;
  logic       RST_HazU;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, JumpD, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, MemTimeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] StallCnt;
`endif
  logic [6:0] ctl;

  int nCmp = 0;
  int nMis = 0;
  int expCnt = 0;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always #5 CLK_HazU = ~CLK_HazU;

  hazard_ctrl_unit #(.MEM_TIMEOUT(4)) dut (
    .CLK_HazU  (CLK_HazU),
    .RST_HazU  (RST_HazU),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .PCSrcD    (PCSrcD),
    .JumpD     (JumpD),
    .MemReqM   (MemReqM),
    .MemReadyM (MemReadyM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushW    (FlushW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .MemTimeout(MemTimeout)
`ifdef HAZ_PERF_CNT_EN
    ,
    .StallCnt  (StallCnt)
`endif
  );

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_HazU);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearIn();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; JumpD = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  // ctl bit order: StallF StallD StallE StallM FlushD FlushE FlushW
  initial begin
    clearIn();
    RST_HazU = 1'b1;
    tick();
    tick();
    RsE = 5; WriteRegM = 5; RegWriteM = 1;
    settle();
    chkVal("rst ctl", 32'(ctl), 32'b0000111);
    chkVal("rst fwdAE", 32'(ForwardAE), 32'd0);
    chkVal("rst timeout", 32'(MemTimeout), 32'd0);
    clearIn();
    RST_HazU = 1'b0;
    settle();
    chkVal("idle ctl", 32'(ctl), 32'd0);

    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    settle();
    chkVal("fwdAE M prio", 32'(ForwardAE), 32'd2);
    RegWriteM = 0;
    settle();
    chkVal("fwdAE W", 32'(ForwardAE), 32'd1);
    RsE = 0; WriteRegM = 0; RegWriteM = 1; WriteRegW = 0;
    settle();
    chkVal("fwdAE r0", 32'(ForwardAE), 32'd0);
    RtE = 7; WriteRegW = 7; WriteRegM = 7; RegWriteM = 0;
    settle();
    chkVal("fwdBE W", 32'(ForwardBE), 32'd1);
    chkVal("fwdAE none", 32'(ForwardAE), 32'd0);

    clearIn();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtE = 8; RsD = 8;
    settle();
    chkVal("lw ctl", 32'(ctl), 32'b1100010);
    tick(); expCnt++;
    clearIn();
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8; RsE = 8; MemReqM = 1; MemReadyM = 1;
    settle();
    chkVal("lw after ctl", 32'(ctl), 32'd0);
    chkVal("lw after fwdAE", 32'(ForwardAE), 32'd2);
    tick();

    clearIn();
    BranchD = 1; RegWriteE = 1; WriteRegE = 3; RtD = 3; RsD = 1;
    settle();
    chkVal("br ctl", 32'(ctl), 32'b1100010);
    tick(); expCnt++;
    clearIn();
    BranchD = 1; RsD = 1; RtD = 3; RegWriteM = 1; WriteRegM = 3;
    settle();
    chkVal("br fwd ctl", 32'(ctl), 32'd0);
    chkVal("br fwdBD", 32'(ForwardBD), 32'd1);
    chkVal("br fwdAD", 32'(ForwardAD), 32'd0);
    PCSrcD = 1;
    settle();
    chkVal("taken ctl", 32'(ctl), 32'b0000100);
    PCSrcD = 0; MemtoRegM = 1;
    settle();
    chkVal("br ld M ctl", 32'(ctl), 32'b1100010);
    clearIn();
    BranchD = 1; RegWriteE = 1; WriteRegE = 0; RsD = 0;
    settle();
    chkVal("br r0 ctl", 32'(ctl), 32'd0);
    clearIn();
    JumpD = 1;
    settle();
    chkVal("jump ctl", 32'(ctl), 32'b0000100);
    clearIn();
    tick();

    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chkVal($sformatf("memwait ctl %0d", i), 32'(ctl), 32'b1111001);
      tick(); expCnt++;
    end
    MemReadyM = 1;
    settle();
    chkVal("memready ctl", 32'(ctl), 32'd0);
    tick();
    clearIn();
    settle();
    chkVal("mem back RUN ctl", 32'(ctl), 32'd0);
    chkVal("mem no timeout", 32'(MemTimeout), 32'd0);

    MemReqM = 1; MemReadyM = 0;
    settle();
    chkVal("to ctl 0", 32'(ctl), 32'b1111001);
    tick(); expCnt++;
    MemtoRegE = 1; RtE = 8; RsD = 8;
    settle();
    chkVal("to ctl 1 prio", 32'(ctl), 32'b1111001);
    tick(); expCnt++;
    MemtoRegE = 0; RtE = 0; RsD = 0;
    settle();
    chkVal("to ctl 2", 32'(ctl), 32'b1111001);
    tick(); expCnt++;
    settle();
    chkVal("to abort ctl", 32'(ctl), 32'b0000001);
    chkVal("to flag pre", 32'(MemTimeout), 32'd0);
    tick();
    clearIn();
    settle();
    chkVal("to flag set", 32'(MemTimeout), 32'd1);
    chkVal("to resume ctl", 32'(ctl), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chkVal("stallcnt", StallCnt, 32'(expCnt));
`endif
    tick();
    settle();
    chkVal("to flag sticky", 32'(MemTimeout), 32'd1);

    MemReqM = 1; MemReadyM = 0;
    tick(); expCnt++;
    tick(); expCnt++;
    RST_HazU = 1'b1;
    settle();
    chkVal("rst mid ctl", 32'(ctl), 32'b0000111);
    tick();
    RST_HazU = 1'b0;
    clearIn();
    settle();
    chkVal("rst mid RUN ctl", 32'(ctl), 32'd0);
    chkVal("rst mid timeout", 32'(MemTimeout), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chkVal("rst stallcnt", StallCnt, 32'd0);
`endif
    tick();
    settle();
    chkVal("rst mid no late abort", 32'(ctl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
